// File: rtl/demux_pkg.sv
// ============================================================================
//  demux_pkg : shared constants and types for the 64-bit buffered demux
//  Revision  : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int DEMUX_WIDTH = 64;
    localparam int DEMUX_DEPTH = 2;
    localparam int DEMUX_CW    = 16;
    localparam int DEMUX_OUTS  = 2;

    typedef logic [DEMUX_WIDTH-1:0] word_t;

endpackage : demux_pkg

`default_nettype wire

// File: rtl/fifo_buf.sv
// ============================================================================
//  fifo_buf : per-output FIFO with occupancy and accepted-word counter
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CW-1:0]            acc,
    output logic                     full
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    assign out_valid = (count != '0);
    assign full      = (count == FULL_COUNT);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Push is already qualified with !full by the caller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            acc    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
                acc         <= acc + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : fifo_buf

`default_nettype wire

// File: rtl/demux64_2_buf.sv
// ============================================================================
//  demux64_2_buf : valid/ready 1-to-2 demultiplexer with a FIFO per output
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module demux64_2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH,
    parameter int CW    = DEMUX_CW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out0_data,
    output logic [WIDTH-1:0]         out1_data,
    output logic                     out0_valid,
    output logic                     out1_valid,
    input  logic                     out0_ready,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   count0,
    output logic [$clog2(DEPTH):0]   count1,
    output logic [CW-1:0]            acc0,
    output logic [CW-1:0]            acc1
);

    logic [WIDTH-1:0]        fifo_data  [DEMUX_OUTS];
    logic                    fifo_valid [DEMUX_OUTS];
    logic                    fifo_ready [DEMUX_OUTS];
    logic [$clog2(DEPTH):0]  fifo_count [DEMUX_OUTS];
    logic [CW-1:0]           fifo_acc   [DEMUX_OUTS];
    logic                    fifo_full  [DEMUX_OUTS];
    logic                    push       [DEMUX_OUTS];

    // Ready depends only on the selected FIFO's occupancy: no pass-through.
    assign in_ready = !fifo_full[in_sel];

    assign fifo_ready[0] = out0_ready;
    assign fifo_ready[1] = out1_ready;

    generate
        for (genvar k = 0; k < DEMUX_OUTS; k++) begin : g_out
            assign push[k] = in_valid && in_ready && (in_sel == 1'(k));

            fifo_buf #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .CW    (CW)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (push[k]),
                .push_data (in_data),
                .out_data  (fifo_data[k]),
                .out_valid (fifo_valid[k]),
                .out_ready (fifo_ready[k]),
                .count     (fifo_count[k]),
                .acc       (fifo_acc[k]),
                .full      (fifo_full[k])
            );
        end
    endgenerate

    assign out0_data  = fifo_data[0];
    assign out1_data  = fifo_data[1];
    assign out0_valid = fifo_valid[0];
    assign out1_valid = fifo_valid[1];
    assign count0     = fifo_count[0];
    assign count1     = fifo_count[1];
    assign acc0       = fifo_acc[0];
    assign acc1       = fifo_acc[1];

endmodule : demux64_2_buf

`default_nettype wire

// File: tb/tb_demux64_2_buf.sv
// ============================================================================
//  tb_demux64_2_buf : scoreboard bench for demux64_2_buf (default and CW=4)
//  Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_demux64_2_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic        in_sel, in_valid, in_ready;
    logic [63:0] out0_data, out1_data;
    logic        out0_valid, out1_valid, out0_ready, out1_ready;
    logic [1:0]  count0, count1;
    logic [15:0] acc0, acc1;

    logic [63:0] w_in_data;
    logic        w_in_sel, w_in_valid, w_in_ready;
    logic [63:0] w_out0_data, w_out1_data;
    logic        w_out0_valid, w_out1_valid, w_out0_ready, w_out1_ready;
    logic [1:0]  w_count0, w_count1;
    logic [3:0]  w_acc0, w_acc1;

    logic [63:0] exp0 [$];
    logic [63:0] exp1 [$];
    logic [63:0] expw [$];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demux64_2_buf dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out1_data(out1_data),
        .out0_valid(out0_valid), .out1_valid(out1_valid),
        .out0_ready(out0_ready), .out1_ready(out1_ready),
        .count0(count0), .count1(count1), .acc0(acc0), .acc1(acc1)
    );

    demux64_2_buf #(.WIDTH(64), .DEPTH(2), .CW(4)) dut_w (
        .clk(clk), .reset(reset), .in_data(w_in_data), .in_sel(w_in_sel),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .out0_data(w_out0_data), .out1_data(w_out1_data),
        .out0_valid(w_out0_valid), .out1_valid(w_out1_valid),
        .out0_ready(w_out0_ready), .out1_ready(w_out1_ready),
        .count0(w_count0), .count1(w_count1), .acc0(w_acc0), .acc1(w_acc1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; acceptance is judged mid-cycle.
    task automatic step(input logic v, input logic s, input logic [63:0] d,
                        input logic r0, input logic r1);
        @(posedge clk);
        #1;
        in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
        @(negedge clk);
        if (v && in_ready) begin
            if (s) exp1.push_back(d);
            else   exp0.push_back(d);
        end
    endtask

    task automatic wstep(input logic v, input logic [63:0] d);
        @(posedge clk);
        #1;
        w_in_valid = v; w_in_sel = 1'b1; w_in_data = d;
        @(negedge clk);
        if (v && w_in_ready) expw.push_back(d);
    endtask

    task automatic mon_pop(input string name, input logic [63:0] data, inout logic [63:0] q [$]);
        if (q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: got %h expected no word", name, data);
        end else begin
            check(name, data, q.pop_front());
        end
    endtask

    // Monitor: every word the consumer takes must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (out0_valid && out0_ready)     mon_pop("out0_order", out0_data, exp0);
            if (out1_valid && out1_ready)     mon_pop("out1_order", out1_data, exp1);
            if (w_out1_valid && w_out1_ready) mon_pop("wrap_order", w_out1_data, expw);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_data = '0; in_sel = 1'b0; in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        w_in_data = '0; w_in_sel = 1'b1; w_in_valid = 1'b0; w_out0_ready = 1'b0; w_out1_ready = 1'b1;
        #12;
        check("rst_out0_valid", 64'(out0_valid), 64'd0);
        check("rst_out1_valid", 64'(out1_valid), 64'd0);
        check("rst_out0_data",  out0_data, 64'd0);
        check("rst_count0",     64'(count0), 64'd0);
        check("rst_acc1",       64'(acc1), 64'd0);
        check("rst_in_ready",   64'(in_ready), 64'd1);
        @(posedge clk); #1; reset = 1'b0;

        // Basic routing
        step(1'b1, 1'b0, 64'h0123456789ABCDEF, 1'b0, 1'b0);
        step(1'b1, 1'b1, 64'hFEDCBA9876543210, 1'b0, 1'b0);
        check("route_out0_valid", 64'(out0_valid), 64'd1);
        check("route_out0_data",  out0_data, 64'h0123456789ABCDEF);
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check("route_out1_valid", 64'(out1_valid), 64'd1);
        check("route_out1_data",  out1_data, 64'hFEDCBA9876543210);
        check("route_count0", 64'(count0), 64'd1);
        check("route_count1", 64'(count1), 64'd1);
        check("route_acc0",   64'(acc0), 64'd1);
        check("route_acc1",   64'(acc1), 64'd1);
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        check("route_drained0", 64'(count0), 64'd0);

        // Full and backpressure
        step(1'b1, 1'b0, 64'h1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check("full_count0",   64'(count0), 64'd2);
        check("full_ready_s0", 64'(in_ready), 64'd0);
        step(1'b1, 1'b1, 64'h3, 1'b0, 1'b0);
        check("full_ready_s1", 64'(in_ready), 64'd1);
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check("full_out1_data", out1_data, 64'h3);
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        check("full_drained0", 64'(count0), 64'd0);

        // Simultaneous push/pop with pointer wrap
        step(1'b1, 1'b0, 64'hA, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 64'hB0 + 64'(i), 1'b1, 1'b0);
            check("pp_count0", 64'(count0), 64'd1);
        end
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        check("pp_drained0", 64'(count0), 64'd0);

        // No pass-through when full
        step(1'b1, 1'b0, 64'h10, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h11, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'h12, 1'b1, 1'b0);
        check("npt_ready_full", 64'(in_ready), 64'd0);
        step(1'b1, 1'b0, 64'h12, 1'b1, 1'b0);
        check("npt_ready_next", 64'(in_ready), 64'd1);
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        check("npt_drained0", 64'(count0), 64'd0);

        // Accepted-word counter wrap on a 4-bit counter: 17 pushes -> 1
        for (int i = 0; i < 17; i++) begin
            wstep(1'b1, 64'h100 + 64'(i));
        end
        wstep(1'b0, 64'd0);
        wstep(1'b0, 64'd0);
        check("wrap_acc1", 64'(w_acc1), 64'd1);
        check("wrap_drained", 64'(expw.size()), 64'd0);

        // Asynchronous reset mid-stream with out0 full
        step(1'b1, 1'b0, 64'hAA, 1'b0, 1'b0);
        step(1'b1, 1'b0, 64'hBB, 1'b0, 1'b0);
        step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        check("pre_rst_count0", 64'(count0), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_count0",     64'(count0), 64'd0);
        check("arst_out0_valid", 64'(out0_valid), 64'd0);
        check("arst_out0_data",  out0_data, 64'd0);
        check("arst_acc0",       64'(acc0), 64'd0);
        exp0.delete();
        exp1.delete();
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        in_sel = 1'b0; #1;
        check("post_rst_ready_s0", 64'(in_ready), 64'd1);
        in_sel = 1'b1; #1;
        check("post_rst_ready_s1", 64'(in_ready), 64'd1);

        check("exp0_drained", 64'(exp0.size()), 64'd0);
        check("exp1_drained", 64'(exp1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_demux64_2_buf

`default_nettype wire
